axis_uart_tx_arbiter: RTL and testbench
=======================================

// Module: axis_uart_tx_arbiter
// PURPOSE
//  Round-robin, packet-locked arbiter sharing the single AXI-Stream byte input of
//  the UART transmit path (top_axis_uart) between N_SRC byte-stream requesters.
//  Once a source is granted, it keeps the path until its tlast beat is accepted.
//  A stall timer reclaims the path from a source that stops mid-packet.
// PARAMETERS
//  N_SRC      4      number of requesters, 2..8
//  STALL_MAX  1024   idle cycles tolerated mid-packet before forced release; 0 = disabled
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        asynchronous, active-low reset (asserts immediately, releases on clk)
//  s_axis_data   in   8*N_SRC  source i byte at [8*i+7:8*i]
//  s_axis_valid  in   N_SRC    per-source valid
//  s_axis_last   in   N_SRC    per-source end-of-packet
//  s_axis_ready  out  N_SRC    per-source ready
//  m_axis_data   out  8        byte to UART TX path
//  m_axis_valid  out  1        valid to UART TX path
//  m_axis_last   out  1        last to UART TX path
//  m_axis_ready  in   1        UART TX path accepts byte
//  grant         out  N_SRC    one-hot current owner; all-zero when idle
//  busy          out  1        high while any source owns the path
//  stall_err     out  1        one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (rst=0): grant=0, busy=0, stall_err=0, s_axis_ready=0, m_axis_valid=0,
//   m_axis_last=0, m_axis_data=0, rr pointer=0, stall counter=0, state=IDLE.
//  States: IDLE, LOCK.
//  IDLE: if any s_axis_valid, select the first requester at or after rr pointer
//   (wrapping N_SRC-1 -> 0); register grant, enter LOCK on the next edge.
//   s_axis_ready=0 and m_axis_valid=0 while in IDLE.
//  Latency: a request seen in IDLE produces m_axis_valid on the following cycle (1 clk).
//  LOCK (owner g): combinational pass-through: m_axis_data/valid/last =
//   s_axis_*[g]; s_axis_ready[g]=m_axis_ready; other s_axis_ready bits = 0.
//  Transfer = m_axis_valid & m_axis_ready. Transfer with last -> grant=0, rr=g+1
//   (mod N_SRC), state=IDLE on the next edge; no idle-gap penalty beyond 1 cycle.
//  A single-beat packet (valid & last on its first beat) is legal.
//  Stall counter (16 bit): cleared on entering LOCK and on every transfer;
//   increments each LOCK cycle with s_axis_valid[g]=0; saturates.
//   m_axis_ready=0 with valid=1 is backpressure, not a stall, and does not count.
//  Counter reaching STALL_MAX (STALL_MAX!=0): stall_err=1 for one cycle,
//   grant=0, rr=g+1, state=IDLE; no byte or last is injected downstream.
//  Non-owner valid/last/data are ignored; sources must hold data stable while
//   valid & !ready (AXI-S rule); the arbiter does not buffer.
//  Simultaneous: owner's last transfer and other requests in the same cycle ->
//   the new grant is decided in the following IDLE cycle from the updated rr.
//  Reset mid-packet: the packet is abandoned; all outputs return to reset values.
// TESTING
//  1 Reset: rst=0 for 2 clk with s_axis_valid=4'b1111 -> grant=0, m_axis_valid=0, ready=0.
//  2 Round-robin: all 4 sources send 1-byte packets (0x10,0x20,0x30,0x40), ready=1 ->
//    output order 0x10,0x20,0x30,0x40, then 0x10 again; grant 0001->0010->0100->1000.
//  3 Packet lock: src0 sends 3 bytes 0x0A,0x14,0x14 (last on 3rd) while src1 valid ->
//    all 3 src0 bytes pass contiguously, src1 first byte follows 1 idle cycle later.
//  4 Backpressure: m_axis_ready=0 for 5000 clk mid-packet, STALL_MAX=1024 ->
//    no stall_err, data held stable, packet completes when ready returns.
//  5 Stall: src2 drops valid after 1st byte for 1024 clk -> stall_err pulse on
//    cycle 1024, grant clears, src3 granted next.
//  6 Reset mid-packet: assert rst after byte 2 of 4 -> outputs to reset values
//    within the same cycle; after release, src0 granted first (rr=0).

Source files
------------

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares the single AXI-Stream byte
// input of the UART transmit path between N_SRC byte-stream requesters.
// A granted source keeps the path until its tlast beat is accepted. A stall
// timer reclaims the path from an owner that stops presenting data mid-packet.
module axis_uart_tx_arbiter #(
  parameter int unsigned N_SRC     = 4,    // 2..8 requesters
  parameter int unsigned STALL_MAX = 1024  // idle owner cycles before forced release; 0 = off
) (
  input  logic               clk,
  input  logic               rst,          // asynchronous, active-low
  input  logic [8*N_SRC-1:0] s_axis_data,
  input  logic [N_SRC-1:0]   s_axis_valid,
  input  logic [N_SRC-1:0]   s_axis_last,
  output logic [N_SRC-1:0]   s_axis_ready,
  output logic [7:0]         m_axis_data,
  output logic               m_axis_valid,
  output logic               m_axis_last,
  input  logic               m_axis_ready,
  output logic [N_SRC-1:0]   grant,
  output logic               busy,
  output logic               stall_err
);

  localparam int unsigned IDX_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  // One bit wider than the counter so a 65536 limit is still reachable.
  localparam logic [16:0] STALL_LIM = 17'(STALL_MAX);

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [15:0]        stall_q, stall_d;
  logic               stall_err_q, stall_err_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;

  logic [7:0]         own_data;
  logic               own_valid;
  logic               own_last;
  logic               xfer;

  // Modular add on source indices (wraps N_SRC-1 -> 0 for any N_SRC).
  function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                               input int unsigned       b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= N_SRC) s = s - N_SRC;
    return IDX_W'(s);
  endfunction

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand_idx = add_mod(rr_q, k);
      if (!pick_found && s_axis_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Select the owner's stream fields using the one-hot grant.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (grant_q[k]) begin
        own_data  = own_data | s_axis_data[8*k +: 8];
        own_valid = own_valid | s_axis_valid[k];
        own_last  = own_last | s_axis_last[k];
      end
    end
  end

  assign xfer = (state_q == LOCK) && own_valid && m_axis_ready;

  // Next-state logic: grant in IDLE, release on tlast transfer or stall limit.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    stall_d     = stall_q;
    stall_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCK;
          owner_d = pick_idx;
          grant_d = {{(N_SRC-1){1'b0}}, 1'b1} << pick_idx;
          stall_d = '0;
        end
      end
      LOCK: begin
        if (xfer && own_last) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = add_mod(owner_q, 1);
          stall_d = '0;
        end else if (xfer) begin
          stall_d = '0;
        end else if (!own_valid) begin
          // Only an absent owner counts; valid held under backpressure does not.
          if ((STALL_MAX != 0) && (({1'b0, stall_q} + 17'd1) == STALL_LIM)) begin
            stall_err_d = 1'b1;
            state_d     = IDLE;
            grant_d     = '0;
            rr_d        = add_mod(owner_q, 1);
            stall_d     = '0;
          end else if (stall_q != '1) begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      stall_q     <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      stall_q     <= stall_d;
      stall_err_q <= stall_err_d;
    end
  end

  // Combinational pass-through while locked; everything quiet while idle.
  always_comb begin
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    if (state_q == LOCK) begin
      m_axis_data  = own_data;
      m_axis_valid = own_valid;
      m_axis_last  = own_last;
      s_axis_ready = grant_q & {N_SRC{m_axis_ready}};
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == LOCK);
  assign stall_err = stall_err_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));
  a_lock_has_owner: assert property (@(posedge clk) disable iff (!rst)
                                     (state_q == LOCK) |-> $onehot(grant_q));
  a_idle_no_grant: assert property (@(posedge clk) disable iff (!rst)
                                    (state_q == IDLE) |-> (grant_q == '0));

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Scoreboard bench for axis_uart_tx_arbiter: a packet-level round-robin model
// predicts the downstream byte order; a monitor checks every accepted beat.
module tb_axis_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [8*N-1:0] s_axis_data  = '0;
  logic [N-1:0]   s_axis_valid = '0;
  logic [N-1:0]   s_axis_last  = '0;
  logic [N-1:0]   s_axis_ready;
  logic [7:0]     m_axis_data;
  logic           m_axis_valid;
  logic           m_axis_last;
  logic           m_axis_ready = 1'b1;
  logic [N-1:0]   grant;
  logic           busy;
  logic           stall_err;

  axis_uart_tx_arbiter #(.N_SRC(N), .STALL_MAX(1024)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .grant(grant), .busy(busy), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         s;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         xfer_cyc[$];
  int         model_rr = 0;
  logic [7:0] pd[N][$];
  logic       pl[N][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted downstream beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && m_axis_valid && m_axis_ready) begin
      xfer_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("beat_data", m_axis_data, e.d);
        check("beat_last", m_axis_last, e.l);
        check("beat_grant", grant, 32'(1) << e.s);
        check("beat_s_ready", s_axis_ready, 32'(1) << e.s);
      end
    end
  end

  // Packet-level round robin over sources that still hold whole packets.
  task automatic build_expected();
    int pos[N];
    bit found;
    int s;
    exp_t e;
    for (int i = 0; i < N; i++) pos[i] = 0;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        s = (model_rr + k) % N;
        if (!found && pos[s] < pd[s].size()) begin
          found = 1'b1;
          do begin
            e.d = pd[s][pos[s]];
            e.l = pl[s][pos[s]];
            e.s = s;
            sb.push_back(e);
            pos[s]++;
          end while (!e.l && pos[s] < pd[s].size());
          model_rr = (s + 1) % N;
        end
      end
    end
  endtask

  // Drive the loaded packet queues; valid stays up whenever a source has data,
  // except optional gaps inside a packet the source already started.
  task automatic run_engine(input bit rnd_ready, input bit gaps, input int budget);
    bit pres[N];
    bit mid[N];
    bit hs[N];
    bit pending;
    int cnt;
    build_expected();
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0;
      mid[i]  = 1'b0;
    end
    cnt = 0;
    pending = 1'b1;
    while (pending && cnt < budget) begin
      for (int i = 0; i < N; i++) begin
        if (pd[i].size() != 0 && !pres[i]) begin
          if (!(gaps && mid[i] && $urandom_range(0, 3) == 0)) pres[i] = 1'b1;
        end
        s_axis_valid[i] = pres[i];
        if (pres[i]) begin
          s_axis_data[8*i +: 8] = pd[i][0];
          s_axis_last[i]        = pl[i][0];
        end
      end
      m_axis_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) hs[i] = s_axis_valid[i] & s_axis_ready[i];
      @(posedge clk);
      #1;
      cnt++;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          mid[i] = !pl[i][0];
          void'(pd[i].pop_front());
          void'(pl[i].pop_front());
          pres[i] = 1'b0;
        end
      end
      pending = (sb.size() != 0);
      for (int i = 0; i < N; i++) if (pd[i].size() != 0) pending = 1'b1;
    end
    checks++;
    if (pending) begin
      errors++;
      $display("FAIL engine_timeout: got %0d beats outstanding after %0d cycles, expected 0",
               sb.size(), budget);
    end
    s_axis_valid = '0;
    s_axis_last  = '0;
    m_axis_ready = 1'b1;
  endtask

  task automatic wait_hs(input int i, input string name);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = s_axis_valid[i] & s_axis_ready[i];
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no handshake in 200 cycles, expected one", name);
    end
  endtask

  task automatic do_reset();
    s_axis_valid = '0;
    s_axis_last  = '0;
    m_axis_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    model_rr = 0;
  endtask

  task automatic add_pkt(input int src, input int len, input logic [7:0] base, input bit rnd);
    for (int b = 0; b < len; b++) begin
      pd[src].push_back(rnd ? 8'($urandom_range(0, 255)) : base + 8'(b));
      pl[src].push_back(b == len - 1);
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got no finish by cycle 60000, expected finish");
    $fatal(1);
  end

  initial begin
    int start;
    int pulses;
    int unstable;
    int exp_cyc[4];

    // Reset with every source requesting.
    s_axis_valid = 4'b1111;
    s_axis_data  = 32'h44332211;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_m_valid", m_axis_valid, 0);
    check("rst_s_ready", s_axis_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_m_data", m_axis_data, 0);
    check("rst_m_last", m_axis_last, 0);
    s_axis_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin over single-byte packets, two rounds.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) add_pkt(i, 1, 8'(16 * (i + 1)), 1'b0);
    run_engine(1'b0, 1'b0, 200);

    // Packet lock and one-cycle idle gap.
    pd[0].push_back(8'h0A); pl[0].push_back(1'b0);
    pd[0].push_back(8'h14); pl[0].push_back(1'b0);
    pd[0].push_back(8'h14); pl[0].push_back(1'b1);
    add_pkt(1, 2, 8'h55, 1'b0);
    xfer_cyc.delete();
    start = cyc;
    exp_cyc = '{start + 1, start + 2, start + 3, start + 5};
    run_engine(1'b0, 1'b0, 200);
    check("lock_beats", xfer_cyc.size(), 5);
    for (int k = 0; k < 4; k++)
      check("lock_cycle", (k < xfer_cyc.size()) ? xfer_cyc[k] : -1, exp_cyc[k]);

    // Long backpressure mid-packet is not a stall.
    s_axis_valid[1] = 1'b1; s_axis_data[15:8] = 8'h61; s_axis_last[1] = 1'b0;
    sb.push_back('{8'h61, 1'b0, 1});
    wait_hs(1, "bp_beat0");
    s_axis_data[15:8] = 8'h62;
    m_axis_ready = 1'b0;
    sb.push_back('{8'h62, 1'b0, 1});
    pulses = 0;
    unstable = 0;
    repeat (5000) begin
      @(negedge clk);
      if (stall_err !== 1'b0) pulses++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== 8'h62) unstable++;
    end
    check("bp_stall_pulses", pulses, 0);
    check("bp_unstable_cycles", unstable, 0);
    check("bp_busy", busy, 1);
    @(posedge clk);
    #1;
    m_axis_ready = 1'b1;
    wait_hs(1, "bp_beat1");
    s_axis_data[15:8] = 8'h63;
    s_axis_last[1] = 1'b1;
    sb.push_back('{8'h63, 1'b1, 1});
    wait_hs(1, "bp_beat2");
    s_axis_valid = '0;
    s_axis_last  = '0;
    model_rr = 2;
    check("bp_sb_empty", sb.size(), 0);

    // Randomized packets with random backpressure and owner gaps.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(i, $urandom_range(1, 5), 8'h00, 1'b1);
      end
      run_engine(1'b1, 1'b1, 3000);
    end

    // Stall: src2 goes silent after its first byte.
    do_reset();
    s_axis_valid[2] = 1'b1; s_axis_data[23:16] = 8'hA1; s_axis_last[2] = 1'b0;
    s_axis_valid[3] = 1'b1; s_axis_data[31:24] = 8'hB1; s_axis_last[3] = 1'b1;
    sb.push_back('{8'hA1, 1'b0, 2});
    wait_hs(2, "stall_beat0");
    s_axis_valid[2] = 1'b0;
    pulses = 0;
    repeat (1023) begin
      @(posedge clk);
      #1;
      if (stall_err !== 1'b0) pulses++;
    end
    check("stall_early_pulses", pulses, 0);
    @(posedge clk);
    #1;
    check("stall_err_pulse", stall_err, 1);
    check("stall_grant_clear", grant, 0);
    check("stall_busy_clear", busy, 0);
    sb.push_back('{8'hB1, 1'b1, 3});
    @(posedge clk);
    #1;
    check("stall_err_one_cycle", stall_err, 0);
    check("stall_next_grant", grant, 4'b1000);
    wait_hs(3, "stall_src3");
    s_axis_valid = '0;
    s_axis_last  = '0;
    model_rr = 0;

    // Reset mid-packet: src3 abandons a 4-byte packet after byte 2.
    s_axis_valid[3] = 1'b1; s_axis_data[31:24] = 8'hC1; s_axis_last[3] = 1'b0;
    sb.push_back('{8'hC1, 1'b0, 3});
    sb.push_back('{8'hC2, 1'b0, 3});
    wait_hs(3, "rstmid_beat0");
    s_axis_data[31:24] = 8'hC2;
    wait_hs(3, "rstmid_beat1");
    s_axis_data[31:24] = 8'hC3;
    #1;
    rst = 1'b0;
    #1;
    check("rstmid_grant", grant, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_m_valid", m_axis_valid, 0);
    check("rstmid_m_data", m_axis_data, 0);
    check("rstmid_m_last", m_axis_last, 0);
    check("rstmid_s_ready", s_axis_ready, 0);
    check("rstmid_stall_err", stall_err, 0);
    check("rstmid_sb_empty", sb.size(), 0);
    s_axis_valid = '0;
    s_axis_last  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_rr = 0;
    for (int i = 0; i < N; i++) add_pkt(i, 1, 8'(8'hD0 + 8'(i)), 1'b0);
    run_engine(1'b0, 1'b0, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
